// File: rtl/ps02_alu_pipe_if.sv
// Operand/opcode stream into the PS02 ALU pipe and its registered result/flag outputs.
// Valid-only stream: no ready. The producer may assert in_valid every cycle, and
// every beat is accepted. Each accepted beat yields exactly one out_valid pulse.
interface ps02_alu_pipe_if #(
  parameter int data_width = 32
);
  logic                  in_valid;
  logic [data_width-1:0] A;
  logic [data_width-1:0] B;
  logic [3:0]            op;
  logic                  clr_sticky;
  logic [data_width-1:0] result;
  logic                  out_valid;
  logic                  flag_z;
  logic                  flag_n;
  logic                  flag_c;
  logic                  flag_v;
  logic                  ovf_sticky;

  modport master (
    output in_valid, A, B, op, clr_sticky,
    input  result, out_valid, flag_z, flag_n, flag_c, flag_v, ovf_sticky
  );

  modport slave (
    input  in_valid, A, B, op, clr_sticky,
    output result, out_valid, flag_z, flag_n, flag_c, flag_v, ovf_sticky
  );
endinterface

// File: rtl/ps02_alu_pipe.sv
// Two-stage pipelined ALU: capture stage, then execute with registered result/flags and sticky overflow.
// Optional macro ALU_SAT_EN: saturate signed-overflowing arithmetic ops instead of wrapping.
module ps02_alu_pipe #(
  parameter int data_width = 32
) (
  input logic             clk,
  input logic             rst,
  ps02_alu_pipe_if.slave  bus
);
  localparam int sh_w = $clog2(data_width);

  localparam logic [3:0] op_noop = 4'd0;
  localparam logic [3:0] op_sllb = 4'd1;
  localparam logic [3:0] op_slla = 4'd2;
  localparam logic [3:0] op_decb = 4'd3;
  localparam logic [3:0] op_deca = 4'd4;
  localparam logic [3:0] op_inca = 4'd5;
  localparam logic [3:0] op_incb = 4'd6;
  localparam logic [3:0] op_notb = 4'd7;
  localparam logic [3:0] op_nota = 4'd8;
  localparam logic [3:0] op_xor  = 4'd9;
  localparam logic [3:0] op_nor  = 4'd10;
  localparam logic [3:0] op_or   = 4'd11;
  localparam logic [3:0] op_and  = 4'd12;
  localparam logic [3:0] op_nand = 4'd13;
  localparam logic [3:0] op_add  = 4'd14;
  localparam logic [3:0] op_sub  = 4'd15;

  localparam logic [data_width-1:0] one_val = data_width'(1);

  logic                  s1_valid;
  logic [data_width-1:0] s1_a;
  logic [data_width-1:0] s1_b;
  logic [3:0]            s1_op;

  logic [data_width-1:0] ar_x;
  logic [data_width-1:0] ar_y;
  logic                  ar_sub;
  logic                  is_arith;
  logic [data_width:0]   ar_sum;
  logic                  ar_v;
  logic [data_width-1:0] nxt_res;
  logic                  nxt_c;
  logic                  nxt_v;
  logic                  sticky_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.A;
        s1_b  <= bus.B;
        s1_op <= bus.op;
      end
    end
  end

  // A single (data_width+1)-bit adder/subtractor serves every arithmetic opcode.
  always_comb begin
    ar_x     = s1_a;
    ar_y     = s1_b;
    ar_sub   = 1'b0;
    is_arith = 1'b0;
    case (s1_op)
      op_decb: begin ar_x = s1_b; ar_y = one_val; ar_sub = 1'b1; is_arith = 1'b1; end
      op_deca: begin ar_x = s1_a; ar_y = one_val; ar_sub = 1'b1; is_arith = 1'b1; end
      op_inca: begin ar_x = s1_a; ar_y = one_val; is_arith = 1'b1; end
      op_incb: begin ar_x = s1_b; ar_y = one_val; is_arith = 1'b1; end
      op_add:  begin is_arith = 1'b1; end
      op_sub:  begin ar_sub = 1'b1; is_arith = 1'b1; end
      default: ;
    endcase

    ar_sum = ar_sub ? ({1'b0, ar_x} - {1'b0, ar_y}) : ({1'b0, ar_x} + {1'b0, ar_y});
    if (ar_sub)
      ar_v = (ar_x[data_width-1] != ar_y[data_width-1]) &&
             (ar_sum[data_width-1] != ar_x[data_width-1]);
    else
      ar_v = (ar_x[data_width-1] == ar_y[data_width-1]) &&
             (ar_sum[data_width-1] != ar_x[data_width-1]);

    nxt_res = ar_sum[data_width-1:0];
    nxt_c   = is_arith & ar_sum[data_width];
    nxt_v   = is_arith & ar_v;

    case (s1_op)
      op_sllb: nxt_res = s1_b << s1_a[sh_w-1:0];
      op_slla: nxt_res = s1_a << s1_b[sh_w-1:0];
      op_notb: nxt_res = ~s1_b;
      op_nota: nxt_res = ~s1_a;
      op_xor:  nxt_res = s1_a ^ s1_b;
      op_nor:  nxt_res = ~(s1_a | s1_b);
      op_or:   nxt_res = s1_a | s1_b;
      op_and:  nxt_res = s1_a & s1_b;
      op_nand: nxt_res = ~(s1_a & s1_b);
      default: ;
    endcase

`ifdef ALU_SAT_EN
    // Overflow direction follows the first operand's sign for both add and subtract.
    if (nxt_v)
      nxt_res = ar_x[data_width-1] ? {1'b1, {(data_width-1){1'b0}}}
                                   : {1'b0, {(data_width-1){1'b1}}};
`endif

    // A noop re-presents the held flag_v, so it can still set the sticky bit.
    sticky_set = s1_valid && ((s1_op == op_noop) ? bus.flag_v : nxt_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.result     <= '0;
      bus.flag_z     <= 1'b0;
      bus.flag_n     <= 1'b0;
      bus.flag_c     <= 1'b0;
      bus.flag_v     <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid && (s1_op != op_noop)) begin
        bus.result <= nxt_res;
        bus.flag_z <= (nxt_res == '0);
        bus.flag_n <= nxt_res[data_width-1];
        bus.flag_c <= nxt_c;
        bus.flag_v <= nxt_v;
      end
      if (sticky_set)
        bus.ovf_sticky <= 1'b1;
      else if (bus.clr_sticky)
        bus.ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps02_alu_pipe.sv
// Bench for ps02_alu_pipe: directed and random stream, scoreboard queue fed by an arithmetic reference model.
module tb_ps02_alu_pipe;
  localparam int dw = 32;
  localparam int ew = 32 + dw + 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ps02_alu_pipe_if #(.data_width(dw)) bus ();
  ps02_alu_pipe #(.data_width(dw)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic clr_seen = 1'b0;
  always @(posedge clk) clr_seen = bus.clr_sticky;

  // ---------------- reference model state
  logic [dw-1:0] m_res;
  logic          m_z, m_n, m_c, m_v;
  logic          exp_sticky = 1'b0;
  logic [ew-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [dw-1:0] a, input logic [dw-1:0] b, input logic [3:0] o);
    longint sa   = longint'($signed(a));
    longint sb   = longint'($signed(b));
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint umax = (64'sd1 <<< dw) - 1;
    longint smax = (64'sd1 <<< (dw - 1)) - 1;
    longint smin = -(64'sd1 <<< (dw - 1));
    longint t    = 0;
    logic [63:0] tb_bits;
    logic [dw-1:0] r = '0;
    bit arith = 0;
    bit c = 0;
    bit v = 0;
    case (o)
      4'd0:  return;
      4'd1:  r = b << (a % dw);
      4'd2:  r = a << (b % dw);
      4'd3:  begin arith = 1; t = sb - 1;  c = (ub < 1); end
      4'd4:  begin arith = 1; t = sa - 1;  c = (ua < 1); end
      4'd5:  begin arith = 1; t = sa + 1;  c = (ua + 1 > umax); end
      4'd6:  begin arith = 1; t = sb + 1;  c = (ub + 1 > umax); end
      4'd7:  r = ~b;
      4'd8:  r = ~a;
      4'd9:  r = a ^ b;
      4'd10: r = ~(a | b);
      4'd11: r = a | b;
      4'd12: r = a & b;
      4'd13: r = ~(a & b);
      4'd14: begin arith = 1; t = sa + sb; c = (ua + ub > umax); end
      default: begin arith = 1; t = sa - sb; c = (ua < ub); end
    endcase
    if (arith) begin
      v = (t > smax) || (t < smin);
      tb_bits = t;
      r = tb_bits[dw-1:0];
`ifdef ALU_SAT_EN
      if (t > smax) r = smax[dw-1:0];
      if (t < smin) begin tb_bits = smin; r = tb_bits[dw-1:0]; end
`endif
    end
    m_res = r;
    m_z   = (r == '0);
    m_n   = r[dw-1];
    m_c   = c;
    m_v   = v;
  endfunction

  // ---------------- driver
  task automatic step(input bit v, input logic [dw-1:0] a, input logic [dw-1:0] b,
                      input logic [3:0] o, input bit clr);
    @(negedge clk);
    bus.in_valid   = v;
    bus.A          = a;
    bus.B          = b;
    bus.op         = o;
    bus.clr_sticky = clr;
    if (v) begin
      model(a, b, o);
      exp_q.push_back({cyc, m_res, m_z, m_n, m_c, m_v});
    end
  endtask

  function automatic logic [dw-1:0] pick_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return {1'b0, {(dw-1){1'b1}}};
      2: return {1'b1, {(dw-1){1'b0}}};
      3: return '1;
      4: return 1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard monitor
  initial begin
    logic [ew-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_sticky = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid at cycle %0d: got 1, want 0", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - int'(e[ew-1 -: 32]), 2);
            chk("result",  bus.result, e[dw+3:4]);
            chk("flag_z",  bus.flag_z, e[3]);
            chk("flag_n",  bus.flag_n, e[2]);
            chk("flag_c",  bus.flag_c, e[1]);
            chk("flag_v",  bus.flag_v, e[0]);
            if (e[0]) exp_sticky = 1'b1;
            else if (clr_seen) exp_sticky = 1'b0;
          end
        end else if (clr_seen) begin
          exp_sticky = 1'b0;
        end
        chk("ovf_sticky", bus.ovf_sticky, exp_sticky);
      end
    end
  end

  // ---------------- main sequence
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.op = '0;
    bus.clr_sticky = 1'b0;
    {m_res, m_z, m_n, m_c, m_v} = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
    chk("rst_sticky", bus.ovf_sticky, 0);
    rst = 1'b0;

    // directed vectors
    step(1, 32'hFFFF_FFF2, 32'hFFFF_FC19, 4'd14, 0);
    step(1, 32'hFFFF_FFF1, 32'd37,        4'd15, 0);
    step(1, 32'h0,         32'h0,         4'd15, 0);
    step(1, 32'hDEAD,      32'h1221,      4'd13, 0);
    step(1, 32'hBEEF,      32'h0FF0,      4'd12, 0);
    step(1, 32'h0,         32'h0,         4'd0,  0);
    step(1, 32'h0F0F,      32'hF0F0,      4'd2,  0);
    step(1, 32'h0,         32'hABAB,      4'd1,  0);
    step(1, 32'd31,        32'hFFFF_FFFF, 4'd1,  0);
    step(1, 32'h0,         32'h5,         4'd4,  0);
    step(1, 32'h8000_0000, 32'h1,         4'd15, 0);
    step(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd14, 0);
    step(1, 32'h0,         32'h7FFF_FFFF, 4'd6,  0);
    step(1, 32'h0,         32'h0,         4'd0,  0);
    step(0, 32'h0,         32'h0,         4'd0,  0);
    step(0, 32'h0,         32'h0,         4'd0,  1);
    step(0, 32'h0,         32'h0,         4'd0,  0);
    step(1, 32'h0,         32'h7FFF_FFFF, 4'd6,  0);
    step(0, 32'h0,         32'h0,         4'd0,  1);
    step(0, 32'h0,         32'h0,         4'd0,  0);

    // randomized stream
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, pick_opnd(), pick_opnd(),
           4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    repeat (4) step(0, 32'h0, 32'h0, 4'd0, 0);

    // asynchronous reset with an item in flight
    step(1, 32'h0, 32'h7FFF_FFFF, 4'd6, 0);
    repeat (3) step(0, 32'h0, 32'h0, 4'd0, 0);
    step(1, 32'h1279, 32'hADBF, 4'd9, 0);
    @(posedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_result", bus.result, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
    chk("arst_sticky", bus.ovf_sticky, 0);
    exp_q.delete();
    {m_res, m_z, m_n, m_c, m_v} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) step(0, 32'h0, 32'h0, 4'd0, 0);
    step(1, 32'h3, 32'h4, 4'd14, 0);
    repeat (4) step(0, 32'h0, 32'h0, 4'd0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
